// File: rtl/mio_bus_responder_pkg.sv
// mio_pkg: shared constants and types for the MEM-stage memory/IO responder.
//   - IO register offsets inside the IO page (byte offsets, bits [11:0])
//   - region-select enum produced by the address decoder
//   - IO wait-state FSM state enum
//   - value returned for reads that hit no mapped location
package mio_pkg;

    localparam logic [11:0] MIO_OFS_LED = 12'h000;
    localparam logic [11:0] MIO_OFS_SW  = 12'h004;
    localparam logic [11:0] MIO_OFS_CNT = 12'h008;

    localparam logic [31:0] MIO_UNMAPPED_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_IO,
        SEL_NONE
    } mio_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } mio_state_e;

endpackage

// File: rtl/mio_bus_responder_if.sv
// mio_bus_responder_if: MEM-stage data bus between the CPU and the responder.
//   cpu_req   - access valid, held with the other request fields until mio_ready
//   cpu_we    - 1 = write, 0 = read
//   cpu_addr  - byte address (bits [1:0] ignored)
//   cpu_wdata - write data
//   cpu_rdata - read data, valid while mio_ready=1 on a read
//   mio_ready - access completes at the next rising edge
// Modports: master = CPU side, slave = responder side.
interface mio_bus_responder_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mio_ready;

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_rdata,
        input  mio_ready
    );

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_rdata,
        output mio_ready
    );

endinterface

// File: rtl/mio_bus_responder_data_ram.sv
// mio_data_ram: RAM_WORDS x 32 data memory, asynchronous read, synchronous write.
//   clk   - write clock
//   we    - write enable, sampled on the rising edge
//   addr  - word index (shared by read and write)
//   wdata - write data
//   rdata - combinational read data at addr
// Contents are never reset.
module mio_data_ram #(
    parameter int RAM_WORDS = 1024,
    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: memory/IO responder for the CPU MEM-stage data bus.
//   clk, rst - single clock, asynchronous active-high reset
//   bus      - mio_bus_responder_if.slave (request in, rdata/mio_ready out)
//   sw_in    - switch inputs, read at IO offset 0x4 (no synchronizer)
//   led_out  - LED register, IO offset 0x0
// Regions: RAM below RAM_WORDS*4 answers in the same cycle; IO page
// IO_BASE[31:12] holds LED/SW/CNT; everything else reads 0, drops writes.
// Build option: define MIO_IO_WAIT_STATE_EN to answer IO through a
// wait-state FSM (IDLE/WAIT/DONE, WAIT_CYCLES wait states). Without it IO
// answers combinationally like RAM.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int          RAM_WORDS   = 1024,
    parameter logic [31:0] IO_BASE     = 32'hF000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    mio_bus_responder_if.slave bus,
    input  logic [15:0]        sw_in,
    output logic [15:0]        led_out
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) * 33'd4;

    if (RAM_WORDS < 1 || (RAM_WORDS & (RAM_WORDS - 1)) != 0) begin : g_bad_ram_words
        $error("mio_bus_responder: RAM_WORDS must be a power of two");
    end
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mio_bus_responder: WAIT_CYCLES must be in 1..15");
    end

    mio_sel_e    sel;
    logic [11:0] ofs;
    logic [31:0] io_rdata;
    logic [31:0] io_rd;
    logic [31:0] ram_rdata;
    logic [31:0] cnt;
    logic [31:0] rdata;
    logic        io_ready;
    logic        io_commit;
    logic        ready;
    logic        ram_we;
    logic        led_we;
    logic        cnt_we;

    // RAM wins if a small IO_BASE would overlap it.
    always_comb begin
        sel = SEL_NONE;
        if ({1'b0, bus.cpu_addr} < RAM_LIMIT) begin
            sel = SEL_RAM;
        end else if (bus.cpu_addr[31:12] == IO_BASE[31:12]) begin
            sel = SEL_IO;
        end
    end

    assign ofs = {bus.cpu_addr[11:2], 2'b00};

    always_comb begin
        case (ofs)
            MIO_OFS_LED: io_rdata = {16'h0000, led_out};
            MIO_OFS_SW:  io_rdata = {16'h0000, sw_in};
            MIO_OFS_CNT: io_rdata = cnt;
            default:     io_rdata = 32'h0000_0000;
        endcase
    end

    assign led_we = io_commit & bus.cpu_we & (ofs == MIO_OFS_LED);
    assign cnt_we = io_commit & bus.cpu_we & (ofs == MIO_OFS_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= 16'h0000;
        end else if (led_we) begin
            led_out <= bus.cpu_wdata[15:0];
        end
    end

    // Free-running cycle counter; a software load beats the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 32'h0000_0000;
        end else if (cnt_we) begin
            cnt <= bus.cpu_wdata;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

`ifdef MIO_IO_WAIT_STATE_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    mio_state_e  state;
    mio_state_e  state_next;
    logic [3:0]  wait_cnt;
    logic [31:0] rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping cpu_req during WAIT abandons the access before anything commits.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.cpu_req && sel == SEL_IO) state_next = ST_WAIT;
            ST_WAIT: begin
                if (!bus.cpu_req) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The commit edge is the one that moves WAIT -> DONE.
    always_comb begin
        io_ready  = (state == ST_DONE);
        io_rd     = rd_q;
        io_commit = (state == ST_WAIT) && bus.cpu_req && (wait_cnt == 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            rd_q     <= 32'h0000_0000;
        end else begin
            if (state == ST_IDLE && state_next == ST_WAIT) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (io_commit && !bus.cpu_we) begin
                rd_q <= io_rdata;
            end
        end
    end
`else
    always_comb begin
        io_ready  = 1'b1;
        io_rd     = io_rdata;
        io_commit = bus.cpu_req & (sel == SEL_IO);
    end
`endif

    always_comb begin
        ready = 1'b1;
        rdata = 32'h0000_0000;
        if (rst) begin
            ready = 1'b0;
        end else if (bus.cpu_req) begin
            case (sel)
                SEL_RAM: rdata = ram_rdata;
                SEL_IO: begin
                    ready = io_ready;
                    rdata = io_rd;
                end
                default: rdata = MIO_UNMAPPED_RDATA;
            endcase
        end
    end

    assign bus.mio_ready = ready;
    assign bus.cpu_rdata = rdata;

    assign ram_we = bus.cpu_req & bus.cpu_we & ready & (sel == SEL_RAM);

    mio_data_ram #(
        .RAM_WORDS(RAM_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (bus.cpu_addr[AW+1:2]),
        .wdata(bus.cpu_wdata),
        .rdata(ram_rdata)
    );

endmodule
